// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch, load/store) arbiter and one-cycle sequencer in front of mem_block.
// Tie-break is round-robin when MEM_ARB_RR_EN is defined, otherwise load/store has fixed priority.
module mem_arbiter #(
  parameter int SIZE       = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  localparam int NB        = DATA_WIDTH / SIZE,
  localparam int WB_W      = $clog2(NB) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  ls_req_i,
  input  logic                  ls_we_i,
  input  logic [WB_W-1:0]       ls_bytes_i,
  input  logic [ADDR_WIDTH-1:0] ls_addr_i,
  input  logic [DATA_WIDTH-1:0] ls_wdata_i,
  output logic                  ls_gnt_o,
  output logic                  ls_rvalid_o,
  output logic [DATA_WIDTH-1:0] ls_rdata_o,
  output logic [WB_W-1:0]       mem_write_bits_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic [WB_W-1:0]       bytes_q, bytes_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic                  can_gnt, pick_ls, acc;
  // owner_q changes only on a grant, so it doubles as the last-granted pointer (1 = load/store)
  always_comb begin
    can_gnt = !rst_i && state_q != ACCESS;
`ifdef MEM_ARB_RR_EN
    pick_ls = !owner_q;
`else
    pick_ls = 1'b1;
`endif
    ls_gnt_o = can_gnt && ls_req_i && (!if_req_i || pick_ls);
    if_gnt_o = can_gnt && if_req_i && !ls_gnt_o;
    acc = state_q == ACCESS;
    state_d = (if_gnt_o || ls_gnt_o) ? ACCESS : (acc ? RESP : IDLE);
    owner_d = ls_gnt_o ? 1'b1 : (if_gnt_o ? 1'b0 : owner_q);
    we_d = ls_gnt_o ? ls_we_i : (if_gnt_o ? 1'b0 : we_q);
    addr_d = ls_gnt_o ? ls_addr_i : (if_gnt_o ? if_addr_i : addr_q);
    bytes_d = ls_gnt_o ? (ls_bytes_i > WB_W'(NB) ? WB_W'(NB) : ls_bytes_i) : bytes_q;
    wdata_d = ls_gnt_o ? ls_wdata_i : wdata_q;
    if_rdata_d = (acc && !owner_q) ? mem_data_i : if_rdata_q;
    ls_rdata_d = (acc && owner_q) ? (we_q ? '0 : mem_data_i) : ls_rdata_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      bytes_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      bytes_q    <= bytes_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end
  assign mem_write_bits_o = (!rst_i && state_q == ACCESS && owner_q && we_q) ? bytes_q : '0;
  assign mem_addr_o       = addr_q;
  assign mem_data_o       = wdata_q;
  assign if_rvalid_o      = state_q == RESP && !owner_q;
  assign ls_rvalid_o      = state_q == RESP && owner_q;
  assign if_rdata_o       = if_rdata_q;
  assign ls_rdata_o       = ls_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed stimulus against a transaction-level model with a byte-array memory.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0] if_addr = '0, ls_addr = '0;
  logic [3:0]  ls_bytes = '0;
  logic [63:0] ls_wdata = '0;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid;
  logic [63:0] if_rdata, ls_rdata, mem_data_o, mem_rd;
  logic [3:0]  mem_wb;
  logic [31:0] mem_addr;
  logic [7:0]  dut_mem [0:1023];
  logic [7:0]  ref_mem [0:1023];
  int          n_vec = 0, n_err = 0;
  // model state: access happening this cycle, response due this cycle, held read data
  logic        acc_v = 0, acc_ls = 0, acc_we = 0, rsp_v = 0, rsp_ls = 0, last_ls = 0;
  logic [3:0]  acc_bytes = '0;
  logic [31:0] acc_addr = '0, ref_addr = '0;
  logic [63:0] acc_wdata = '0, ref_if_rd = '0, ref_ls_rd = '0;
  logic        got_ig = 0, got_lg = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_bytes_i(ls_bytes), .ls_addr_i(ls_addr),
    .ls_wdata_i(ls_wdata), .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
    .mem_write_bits_o(mem_wb), .mem_addr_o(mem_addr), .mem_data_o(mem_data_o), .mem_data_i(mem_rd)
  );

  always_comb begin
    mem_rd = '0;
    for (int i = 0; i < 8; i++) mem_rd[8*i +: 8] = dut_mem[mem_addr[9:0] + 10'(i)];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_read(input logic [31:0] a);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = ref_mem[a[9:0] + 10'(i)];
    return r;
  endfunction

  // One clock cycle: check outputs mid-cycle, apply memory writes, advance the model.
  task automatic step();
    logic exp_ig, exp_lg, pick;
    logic [63:0] rd;
    @(negedge clk);
    chk("write_bits", mem_wb, (!rst && acc_v && acc_ls && acc_we) ? acc_bytes : 4'd0);
    chk("mem_addr", mem_addr, ref_addr);
    if (acc_v && acc_we) chk("mem_data", mem_data_o, acc_wdata);
    chk("if_rvalid", if_rvalid, rsp_v && !rsp_ls);
    chk("ls_rvalid", ls_rvalid, rsp_v && rsp_ls);
    chk("if_rdata", if_rdata, ref_if_rd);
    chk("ls_rdata", ls_rdata, ref_ls_rd);
`ifdef MEM_ARB_RR_EN
    pick = !last_ls;
`else
    pick = 1'b1;
`endif
    exp_lg = !rst && !acc_v && ls_req && (!if_req || pick);
    exp_ig = !rst && !acc_v && if_req && !exp_lg;
    chk("if_gnt", if_gnt, exp_ig);
    chk("ls_gnt", ls_gnt, exp_lg);
    got_ig = exp_ig;
    got_lg = exp_lg;
    for (int i = 0; i < 8; i++) if (i < int'(mem_wb)) dut_mem[mem_addr[9:0] + 10'(i)] = mem_data_o[8*i +: 8];
    if (rst) begin
      {acc_v, rsp_v, last_ls} = '0;
      {ref_if_rd, ref_ls_rd, ref_addr} = '0;
    end else begin
      rsp_v = acc_v;
      rsp_ls = acc_ls;
      if (acc_v) begin
        rd = ref_read(acc_addr);
        if (acc_ls) ref_ls_rd = acc_we ? 64'd0 : rd;
        else ref_if_rd = rd;
        if (acc_ls && acc_we)
          for (int i = 0; i < 8; i++) if (i < int'(acc_bytes)) ref_mem[acc_addr[9:0] + 10'(i)] = acc_wdata[8*i +: 8];
      end
      acc_v = exp_ig || exp_lg;
      acc_ls = exp_lg;
      acc_we = exp_lg && ls_we;
      acc_bytes = ls_bytes > 4'd8 ? 4'd8 : ls_bytes;
      acc_wdata = ls_wdata;
      acc_addr = exp_lg ? ls_addr : if_addr;
      if (acc_v) begin
        ref_addr = acc_addr;
        last_ls = exp_lg;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic do_if(input logic [31:0] a);
    if_req = 1'b1;
    if_addr = a;
    got_ig = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (got_ig) break;
    end
    chk("if_grant_seen", got_ig, 1);
    if_req = 1'b0;
    step();
    step();
  endtask

  task automatic do_ls(input logic we, input logic [3:0] n, input logic [31:0] a, input logic [63:0] d);
    ls_req = 1'b1;
    ls_we = we;
    ls_bytes = n;
    ls_addr = a;
    ls_wdata = d;
    got_lg = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (got_lg) break;
    end
    chk("ls_grant_seen", got_lg, 1);
    ls_req = 1'b0;
    step();
    step();
  endtask

  task automatic drive_rand(input int pct);
    if (!if_req || got_ig) begin
      if_req = ($urandom % 100) < pct;
      if_addr = $urandom_range(0, 1023);
    end
    if (!ls_req || got_lg) begin
      ls_req = ($urandom % 100) < pct;
      ls_we = $urandom % 2;
      ls_bytes = 4'($urandom_range(0, 15));
      ls_addr = $urandom_range(0, 1023);
      ls_wdata = {$urandom, $urandom};
    end
  endtask

  initial begin
    int n_if, n_ls;
    logic [63:0] d;
    for (int i = 0; i < 1024; i++) dut_mem[i] = 8'(i * 7);
    for (int i = 0; i < 8; i++) dut_mem[8'h40 + i] = 8'(i + 1);
    dut_mem[10'h100] = 8'h11;
    dut_mem[10'h101] = 8'h22;
    dut_mem[10'h102] = 8'h33;
    dut_mem[10'h103] = 8'h5a;
    dut_mem[10'h300] = 8'h33;
    for (int i = 0; i < 1024; i++) ref_mem[i] = dut_mem[i];
    @(posedge clk);
    #1;
    do_reset();
    do_if(32'h40);
    chk("fetch_0x40", if_rdata, 64'h0807060504030201);
    do_ls(1'b1, 4'd3, 32'h100, 64'hAABBCC);
    chk("store_ack_rdata", ls_rdata, 64'd0);
    do_ls(1'b0, 4'd0, 32'h100, 64'd0);
    chk("partial_store", ls_rdata[31:0], 64'h5AAABBCC);
    d = 64'h1122334455667788;
    do_ls(1'b1, 4'd15, 32'h200, d);
    do_ls(1'b0, 4'd0, 32'h200, 64'd0);
    chk("clamped_store", ls_rdata, d);
    do_ls(1'b1, 4'd0, 32'h200, ~d);
    do_ls(1'b0, 4'd0, 32'h200, 64'd0);
    chk("zero_store", ls_rdata, d);
    do_reset();
    if_req = 1'b1;
    if_addr = 32'h48;
    ls_req = 1'b1;
    ls_we = 1'b0;
    ls_addr = 32'h80;
    n_if = 0;
    n_ls = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      n_if += int'(got_ig);
      n_ls += int'(got_lg);
    end
`ifdef MEM_ARB_RR_EN
    chk("contend_if_grants", 64'(n_if), 64'd3);
    chk("contend_ls_grants", 64'(n_ls), 64'd3);
`else
    chk("contend_if_grants", 64'(n_if), 64'd0);
    chk("contend_ls_grants", 64'(n_ls), 64'd6);
`endif
    if_req = 1'b0;
    ls_req = 1'b0;
    step();
    step();
    ls_req = 1'b1;
    ls_we = 1'b1;
    ls_bytes = 4'd8;
    ls_addr = 32'h300;
    ls_wdata = '1;
    step();
    chk("pre_reset_grant", got_lg, 1);
    ls_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("reset_mem_data", mem_data_o, 64'd0);
    chk("reset_nowrite", dut_mem[10'h300], 8'h33);
    do_ls(1'b0, 4'd0, 32'h300, 64'd0);
    for (int k = 0; k < 1500; k++) begin
      drive_rand(60);
      step();
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    step();
    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer placed directly in front of a single `mem_block` instance. It lets the instruction-fetch port (read-only) and the load/store port (read/write) share one memory. It latches the granted command, drives the memory for exactly one cycle, and returns registered read data with a valid pulse. Tie-breaking between the two requesters is fixed-priority or round-robin, selected at compile time.

## Interface
- `SIZE`, 8, bits per memory byte lane (matches `mem_block`)
- `ADDR_WIDTH`, 32, byte-address width
- `DATA_WIDTH`, 64, access width; `NB = DATA_WIDTH/SIZE` lanes; `WB_W = $clog2(NB)+1`

- `clk_i`  in  1  clock; all state updates on the rising edge
- `rst_i`  in  1  synchronous reset, active-high
- `if_req_i`  in  1  fetch request; held with address until granted
- `if_addr_i`  in  ADDR_WIDTH  fetch byte address
- `if_gnt_o`  out  1  fetch command accepted this cycle
- `if_rvalid_o`  out  1  one-cycle pulse; `if_rdata_o` valid
- `if_rdata_o`  out  DATA_WIDTH  fetch read data
- `ls_req_i`  in  1  load/store request
- `ls_we_i`  in  1  1 = store, 0 = load
- `ls_bytes_i`  in  WB_W  store byte count (lanes 0..n-1); ignored for loads
- `ls_addr_i`  in  ADDR_WIDTH  load/store byte address
- `ls_wdata_i`  in  DATA_WIDTH  store data, lane 0 at the LSBs
- `ls_gnt_o`  out  1  load/store command accepted this cycle
- `ls_rvalid_o`  out  1  one-cycle pulse; load data valid, or store acknowledge
- `ls_rdata_o`  out  DATA_WIDTH  load read data; 0 for stores
- `mem_write_bits_o`  out  WB_W  to `mem_block.write_bits_i`
- `mem_addr_o`  out  ADDR_WIDTH  to `mem_block.addr_i`
- `mem_data_o`  out  DATA_WIDTH  to `mem_block.data_i`
- `mem_data_i`  in  DATA_WIDTH  from `mem_block.data_o` (combinational read)

## Operation
- FSM states: IDLE, ACCESS, RESP.
- Grant:
  - Grant is possible only in IDLE or RESP while `rst_i` = 0.
  - `*_gnt_o` is combinational from the state and the requests.
  - At most one grant per cycle.
  - On grant, latch owner, address, we, clamped byte count and wdata, then go to ACCESS.
- ACCESS (exactly 1 cycle):
  - `mem_addr_o` = latched address; `mem_data_o` = latched wdata.
  - `mem_write_bits_o` = latched byte count for a store; 0 for a load, for fetch, and in every other state.
  - At the end of the cycle: capture `mem_data_i` into the owner's rdata register (store: load 0 instead), then go to RESP.
- RESP:
  - The owner's `*_rvalid_o` = 1.
  - With a new grant, go to ACCESS (back-to-back); otherwise go to IDLE.
- Outside ACCESS, `mem_addr_o` and `mem_data_o` hold their last latched values.
- rdata registers hold their value until the next response to the same port.
- Arbitration:
  - A single requester wins.
  - Tie resolution is per Configuration.
  - The `last` pointer updates on every grant.
- Width rules: a store `ls_bytes_i` > NB is clamped to NB. `ls_bytes_i` = 0 is a legal no-op store; it still completes the full sequence and acknowledges.
- A requester may drop `req` before grant with no effect. Inputs are don't-care after grant.
- No address alignment checks. Wrap-around past the top of memory is `mem_block`'s behaviour and is not handled here.

## Timing
- Latency: grant in cycle N, memory access in N+1, `rvalid` in N+2.
- Throughput: one access per 2 cycles, sustained via the RESP→ACCESS back-to-back path.
- Reset values:
  - state IDLE; `last` = fetch.
  - Both `rvalid` 0; both `rdata` 0.
  - `mem_write_bits_o` 0; `mem_addr_o` 0; `mem_data_o` 0.
  - Both `gnt` 0 during any cycle with `rst_i` = 1.
- Reset mid-operation:
  - `mem_write_bits_o` is gated by `!rst_i`, so no memory write happens in a reset cycle, including ACCESS.
  - Any pending response is discarded; the requester reissues.
- Simultaneous: a RESP for one port and a grant to the other port in the same cycle is legal.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. On a tie, grant the port not granted last. After reset, `last` = fetch, so load/store wins the first tie.
- Not defined: fixed priority. Load/store always wins a tie. `last` is still maintained but unused.

## Test plan
- Reset release, `if_req_i` = 1, `if_addr_i` = 0x40 with memory[0x40..0x47] preloaded to 0x0807060504030201 -> `if_gnt_o` at cycle 0, `if_rvalid_o` at cycle 2, `if_rdata_o` = 0x0807060504030201.
- Store `ls_bytes_i` = 3, `ls_wdata_i` = 0xAABBCC at 0x100, then load 0x100 -> bytes 0x100..0x102 = CC, BB, AA; byte 0x103 unchanged. Store ack has `ls_rdata_o` = 0.
- Both ports request continuously from reset -> RR build grant order LS, IF, LS, IF with rvalid every 2 cycles; non-RR build LS every grant, IF starved.
- Store with `ls_bytes_i` = 15 (NB = 8) -> `mem_write_bits_o` = 8 during ACCESS. Store with `ls_bytes_i` = 0 -> memory unchanged, `ls_rvalid_o` pulses.
- Assert `rst_i` during the ACCESS cycle of a 8-byte store -> memory unchanged, no `ls_rvalid_o`, all outputs at reset values next cycle.
